// File: rtl/power_meas_ctrl.sv
// rtl/power_meas_ctrl.sv - command sequencer that programs power_integrate, runs it and streams per-window results
module power_meas_ctrl #(
  parameter logic [7:0]  SR_SCALE        = 8'd0,
  parameter logic [7:0]  SR_INTEGRATE    = 8'd1,
  parameter logic [7:0]  SR_POWER_ENABLE = 8'd2,
  parameter int unsigned TIMEOUT         = 1048576
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_integrate,
  input  logic [3:0]  cmd_scale,
  input  logic [7:0]  cmd_windows,
  input  logic        abort,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        run,
  input  logic [31:0] power_in,
  input  logic        power_strobe,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  // STOP lands exactly TIMEOUT cycles after the last strobe, hence the -2.
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, CFG_SCALE, CFG_INT, CFG_EN, MEASURE, STOP, DRAIN} state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_integrate;
  logic [7:0]    r_windows;
  logic [7:0]    r_count;
  logic [TW-1:0] r_tmo;
  logic          r_set_stb;
  logic [7:0]    r_set_addr;
  logic [31:0]   r_set_data;
  logic [31:0]   r_tdata;
  logic          r_tlast, r_tvalid, r_done;
  logic [2:0]    r_err;

  logic          w_hs, w_bad, w_strobe, w_load, w_drop, w_final, w_tmo, w_abort;
  logic          w_tvalid_next, w_done_next;
  logic [2:0]    w_err_set;
  logic          w_set_stb;
  logic [7:0]    w_set_addr;
  logic [31:0]   w_set_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_hs          = 1'b0;
    w_bad         = 1'b0;
    w_strobe      = 1'b0;
    w_final       = 1'b0;
    w_tmo         = 1'b0;
    w_set_stb     = 1'b0;
    w_set_addr    = 8'd0;
    w_set_data    = 32'd0;
    w_tvalid_next = r_tvalid && !o_tready;
    w_abort       = abort && (r_state inside {CFG_SCALE, CFG_INT, CFG_EN, MEASURE});
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_hs   = 1'b1;
          w_bad  = (cmd_integrate == 16'd0) || (cmd_windows == 8'd0);
          w_next = w_bad ? IDLE : CFG_SCALE;
        end
      end
      CFG_SCALE: w_next = CFG_INT;
      CFG_INT:   w_next = CFG_EN;
      CFG_EN:    w_next = MEASURE;
      MEASURE: begin
        w_strobe = power_strobe;
        w_final  = power_strobe && (r_count + 8'd1 == r_windows);
        w_tmo    = !power_strobe && (r_tmo == TMO_LIM);
        if (w_final || w_tmo) w_next = STOP;
      end
      STOP:    w_next = DRAIN;
      DRAIN:   if (r_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = STOP;

    w_load = w_strobe && (!r_tvalid || o_tready);
    w_drop = w_strobe && !w_load;
    if (w_load) w_tvalid_next = 1'b1;
    w_err_set   = {w_abort || w_bad, w_drop, w_tmo && !w_abort};
    w_done_next = w_bad || ((w_next == DRAIN) && !w_tvalid_next);

    // Every write state lasts one cycle, so the next state identifies the write to issue.
    case (w_next)
      CFG_SCALE: begin w_set_stb = 1'b1; w_set_addr = SR_SCALE;        w_set_data = {28'd0, cmd_scale}; end
      CFG_INT:   begin w_set_stb = 1'b1; w_set_addr = SR_INTEGRATE;    w_set_data = {16'd0, r_integrate}; end
      CFG_EN:    begin w_set_stb = 1'b1; w_set_addr = SR_POWER_ENABLE; w_set_data = 32'd1; end
      STOP:      begin w_set_stb = 1'b1; w_set_addr = SR_POWER_ENABLE; w_set_data = 32'd0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_integrate <= 16'd0;
      r_windows   <= 8'd0;
      r_count     <= 8'd0;
      r_tmo       <= '0;
      r_set_stb   <= 1'b0;
      r_set_addr  <= 8'd0;
      r_set_data  <= 32'd0;
      r_tdata     <= 32'd0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 3'd0;
    end else begin
      r_set_stb  <= w_set_stb;
      r_set_addr <= w_set_addr;
      r_set_data <= w_set_data;
      r_done     <= w_done_next;
      if (w_hs) begin
        r_integrate <= cmd_integrate;
        r_windows   <= cmd_windows;
        r_err       <= w_err_set;
      end else begin
        r_err <= r_err | w_err_set;
      end
      if (r_state != MEASURE) r_count <= 8'd0;
      else if (w_strobe)      r_count <= r_count + 8'd1;
      if (r_state != MEASURE || w_strobe) r_tmo <= '0;
      else if (r_tmo != TMO_LIM)          r_tmo <= r_tmo + 1'b1;
      r_tvalid <= w_tvalid_next;
      if (w_load) begin
        r_tdata <= power_in;
        r_tlast <= w_final && !w_abort;
      end else begin
        r_tlast <= r_tlast && w_tvalid_next;
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign run       = (r_state == MEASURE);
  assign set_stb   = r_set_stb;
  assign set_addr  = r_set_addr;
  assign set_data  = r_set_data;
  assign o_tdata   = r_tdata;
  assign o_tlast   = r_tlast;
  assign o_tvalid  = r_tvalid;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_power_meas_ctrl.sv
// tb/tb_power_meas_ctrl.sv - scoreboard bench for power_meas_ctrl
module tb_power_meas_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_integrate = 16'd0;
  logic [3:0]  cmd_scale = 4'd0;
  logic [7:0]  cmd_windows = 8'd0;
  logic        abort = 1'b0;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        run;
  logic [31:0] power_in = 32'd0;
  logic        power_strobe = 1'b0;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b0;
  logic        busy;
  logic        done;
  logic [2:0]  err;

  power_meas_ctrl #(.SR_SCALE(8'd0), .SR_INTEGRATE(8'd1), .SR_POWER_ENABLE(8'd2), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_integrate(cmd_integrate), .cmd_scale(cmd_scale), .cmd_windows(cmd_windows),
    .abort(abort), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data), .run(run),
    .power_in(power_in), .power_strobe(power_strobe), .o_tdata(o_tdata), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] a; logic [31:0] b; } ent_t;
  ent_t q_set[$];
  ent_t q_beat[$];
  ent_t q_done[$];
  int total = 0;
  int bad = 0;

  function automatic ent_t mk(input int c, input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    e.c = c; e.a = a; e.b = b;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT output event consumes one scoreboard entry.
  ent_t em;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (set_stb) begin
        if (q_set.size() == 0) chk("set_unexpected", 64'(set_stb), 64'd0);
        else begin
          em = q_set.pop_front();
          chk("set_addr", 64'(set_addr), 64'(em.a));
          chk("set_data", 64'(set_data), 64'(em.b));
          if (em.c >= 0) chk("set_cycle", 64'(cyc), 64'(em.c));
        end
      end else chk("set_idle_zero", {24'd0, set_addr, set_data}, 64'd0);
      if (o_tvalid && o_tready) begin
        if (q_beat.size() == 0) chk("beat_unexpected", 64'(o_tvalid), 64'd0);
        else begin
          em = q_beat.pop_front();
          chk("beat_data", 64'(o_tdata), 64'(em.a));
          chk("beat_last", 64'(o_tlast), 64'(em.b));
          if (em.c >= 0) chk("beat_cycle", 64'(cyc), 64'(em.c));
        end
      end
      if (done) begin
        if (q_done.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else begin
          em = q_done.pop_front();
          chk("done_err", 64'(err), 64'(em.a));
          if (em.c >= 0) chk("done_cycle", 64'(cyc), 64'(em.c));
        end
      end
    end
  end

  task automatic set_ready(input int mode);
    o_tready = (mode == 2) ? 1'($urandom % 2) : 1'b1;
  endtask

  task automatic wait_idle(input int mode);
    int n = 0;
    while ((q_set.size() + q_beat.size() + q_done.size()) != 0 && n < 2000) begin
      step();
      set_ready(mode);
      n++;
    end
    chk("drain_in_time", 64'(n < 2000), 64'd1);
    repeat (4) step();
  endtask

  task automatic issue_cmd(input logic [15:0] integ, input logic [3:0] sc, input logic [7:0] win, output int t0);
    step();
    cmd_valid = 1'b1; cmd_integrate = integ; cmd_scale = sc; cmd_windows = win;
    t0 = cyc;
    if (integ != 0 && win != 0) begin
      q_set.push_back(mk(t0 + 1, 32'd0, {28'd0, sc}));
      q_set.push_back(mk(t0 + 2, 32'd1, {16'd0, integ}));
      q_set.push_back(mk(t0 + 3, 32'd2, 32'd1));
    end
    step();
    cmd_valid = 1'b0;
  endtask

  // mode 0: always ready; 1: not ready until after the final strobe; 2: random ready.
  task automatic do_meas(input logic [15:0] integ, input logic [3:0] sc, input int nwin,
                         input int mode, input int gmin, input int gmax, input logic [31:0] base);
    int t0, s, idx, wait_c;
    bit full, drop;
    logic [31:0] d;
    issue_cmd(integ, sc, 8'(nwin), t0);
    full = 0; drop = 0; idx = 0; s = 0;
    while (cyc < t0 + 3) step();
    chk("run_low_before", 64'(run), 64'd0);
    wait_c = $urandom_range(gmax, gmin);
    while (idx < nwin) begin
      step();
      if (cyc == t0 + 4) chk("run_rise", 64'(run), 64'd1);
      o_tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom % 2);
      wait_c--;
      if (wait_c == 0) begin
        d = (base != 0) ? base * 32'(idx + 1) : $urandom;
        power_strobe = 1'b1; power_in = d; s = cyc;
        if (!full || o_tready) begin
          q_beat.push_back(mk((mode == 0) ? s + 1 : -1, d, 32'(idx == nwin - 1)));
          full = 1;
        end else drop = 1;
        idx++;
        if (idx == nwin) begin
          q_set.push_back(mk(s + 1, 32'd2, 32'd0));
          q_done.push_back(mk((mode == 0) ? s + 2 : -1, {29'd0, 1'b0, drop, 1'b0}, 32'd0));
        end
        wait_c = $urandom_range(gmax, gmin);
      end else begin
        power_strobe = 1'b0;
        if (o_tready) full = 0;
      end
    end
    step();
    power_strobe = 1'b0;
    set_ready(mode);
    chk("run_low_at_stop", 64'(run), 64'd0);
    wait_idle(mode);
  endtask

  initial begin
    int t0, p;
    repeat (3) step();
    chk("reset_outputs", {set_stb, set_addr, set_data, run, o_tdata, o_tlast, o_tvalid, busy, done, err}, 64'd0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    reset_n = 1'b1;
    step();

    do_meas(16'd16, 4'd4, 3, 0, 20, 20, 32'h10);
    do_meas(16'd16, 4'd4, 3, 1, 20, 20, 32'h10);

    // Timeout: one strobe of two windows.
    o_tready = 1'b1;
    issue_cmd(16'd8, 4'd1, 8'd2, t0);
    while (cyc < t0 + 6) step();
    power_strobe = 1'b1; power_in = 32'hCAFE_0001; p = cyc;
    q_beat.push_back(mk(p + 1, 32'hCAFE_0001, 32'd0));
    q_set.push_back(mk(p + 64, 32'd2, 32'd0));
    q_done.push_back(mk(p + 65, 32'd1, 32'd0));
    step();
    power_strobe = 1'b0;
    while (cyc < p + 63) step();
    chk("tmo_run_high", 64'(run), 64'd1);
    step();
    chk("tmo_run_low", 64'(run), 64'd0);
    wait_idle(0);

    // Abort five cycles into MEASURE.
    issue_cmd(16'd32, 4'd2, 8'd4, t0);
    while (cyc < t0 + 9) step();
    abort = 1'b1;
    q_set.push_back(mk(t0 + 10, 32'd2, 32'd0));
    q_done.push_back(mk(t0 + 11, 32'd4, 32'd0));
    step();
    abort = 1'b0;
    chk("abort_run_low", 64'(run), 64'd0);
    wait_idle(0);

    // Illegal commands are rejected in IDLE.
    for (int k = 0; k < 2; k++) begin
      issue_cmd((k == 0) ? 16'd16 : 16'd0, 4'd3, (k == 0) ? 8'd0 : 8'd3, t0);
      q_done.push_back(mk(t0 + 1, 32'd4, 32'd0));
      chk("illegal_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("illegal_busy", 64'(busy), 64'd0);
      wait_idle(0);
    end

    // Reset while a beat is pending.
    issue_cmd(16'd4, 4'd0, 8'd2, t0);
    while (cyc < t0 + 6) step();
    o_tready = 1'b0; power_strobe = 1'b1; power_in = 32'h1234_5678;
    step();
    power_strobe = 1'b0;
    chk("pre_reset_tvalid", 64'(o_tvalid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", {set_stb, set_addr, set_data, run, o_tdata, o_tlast, o_tvalid, busy, done, err}, 64'd0);
    chk("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    reset_n = 1'b1;
    o_tready = 1'b1;
    step();
    do_meas(16'd16, 4'd4, 3, 0, 20, 20, 32'h10);

    for (int r = 0; r < 6; r++)
      do_meas(16'($urandom_range(200, 1)), 4'($urandom), $urandom_range(6, 1), 2, 1, 25, 32'd0);
    for (int r = 0; r < 2; r++)
      do_meas(16'($urandom_range(200, 1)), 4'($urandom), $urandom_range(5, 1), 0, 1, 30, 32'd0);

    chk("queues_empty", 64'(q_set.size() + q_beat.size() + q_done.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/power_meas_ctrl.md
# power_meas_ctrl

Command-driven sequencer for the `power_integrate` datapath. It accepts a measurement command (integration length, scale, window count) and programs the integrator over the shared settings bus. It then drives `run`, collects one 32-bit result per integration window, and presents the results on a ready/valid stream with `last` on the final window. It sits between the host control path and the integrator, and is the only writer of the integrator's settings registers.

## Interface
- `SR_SCALE`, default 8'd0: settings address of the integrator scale register.
- `SR_INTEGRATE`, default 8'd1: settings address of the integration-length register.
- `SR_POWER_ENABLE`, default 8'd2: settings address of the integrator enable register.
- `TIMEOUT`, default 1048576: maximum number of cycles between results before the measurement is aborted. Must be ≥ 2.
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_integrate` in 16: complex samples per window.
- `cmd_scale` in 4: integrator right-shift setting.
- `cmd_windows` in 8: number of windows to report; 0 is illegal.
- `abort` in 1: level; stops the measurement in progress.
- `set_stb` out 1, `set_addr` out 8, `set_data` out 32: settings-bus master to the integrator.
- `run` out 1: integrator run control.
- `power_in` in 32, `power_strobe` in 1: integrator result and its strobe.
- `o_tdata` out 32, `o_tlast` out 1, `o_tvalid` out 1, `o_tready` in 1: result stream.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a measurement.
- `err` out 3: valid with `done` and held until the next accepted command. Bit 0 = timeout, bit 1 = overflow, bit 2 = illegal command or abort.

## Operation
- The FSM has states IDLE, CFG_SCALE, CFG_INT, CFG_EN, MEASURE, STOP, DRAIN.
- IDLE:
  - `cmd_ready=1`.
  - On handshake, latch all command fields and clear `err`.
  - If `cmd_integrate==0` or `cmd_windows==0`: set `err[2]`, pulse `done`, stay in IDLE.
  - Otherwise go to CFG_SCALE.
- CFG_SCALE: write `{28'b0, scale}` to `SR_SCALE`.
- CFG_INT: write `{16'b0, integrate}` to `SR_INTEGRATE`.
- CFG_EN: write 32'd1 to `SR_POWER_ENABLE`. Then go to MEASURE.
- MEASURE:
  - `run=1`. The window counter starts at 0 and the timeout counter starts at 0.
  - Each `power_strobe`: increment the window counter, reset the timeout counter, and load `power_in` into the output register.
  - When the count reaches `cmd_windows`, go to STOP.
- Output register (single entry):
  - A load sets `o_tvalid`, and sets `o_tlast` iff this is the final window.
  - A beat is transferred on `o_tvalid && o_tready`.
  - Strobe arriving while the register is full and not being accepted this cycle: drop the data, set `err[1]` (sticky), still count the window.
  - Strobe arriving in the same cycle the register is accepted: the new data loads and there is no overflow.
- Timeout: if the timeout counter reaches `TIMEOUT` in MEASURE, set `err[0]` and go to STOP.
- `abort` in CFG_* or MEASURE: set `err[2]` and go to STOP. `abort` is ignored in IDLE, STOP and DRAIN.
- STOP (1 cycle):
  - `run=0`.
  - Write 32'd0 to `SR_POWER_ENABLE`. This returns the integrator to bypass.
  - Go to DRAIN.
- DRAIN:
  - Wait until `o_tvalid==0`. The pending beat is never discarded.
  - Then pulse `done` and return to IDLE.
  - On timeout or abort, the last beat delivered does not carry `o_tlast`.
- `power_strobe` outside MEASURE is ignored.
- Settings writes: `set_stb` high for exactly one cycle per write. `set_addr` and `set_data` are 0 whenever `set_stb` is 0.

## Timing
- All outputs are registered, except `cmd_ready`, `busy` and `run`, which are decoded from the registered state.
- Reset values: state IDLE, so `cmd_ready=1`; everything else is 0 (`set_*`, `run`, `o_*`, `busy`, `done`, `err`, counters).
- Command handshake at cycle T:
  - `set_stb` at T+1 (scale), T+2 (integrate), T+3 (enable).
  - `run` rises at T+4.
- Final strobe at cycle S:
  - `o_tvalid`/`o_tlast` are high at S+1.
  - STOP occupies S+1: `set_stb` with enable=0 and `run=0` are visible at S+1.
  - If the beat is accepted at S+1, `done` is high at S+2.
- Asserting `reset_n=0` mid-measurement immediately returns everything to reset values. The integrator enable is not rewritten; the integrator's own reset restores bypass.
- `done` and `cmd_ready` are never high in the same cycle, except for an illegal-command rejection.

## Test plan
- Command integrate=16, scale=4, windows=3, `o_tready=1`, strobes every 20 cycles with data 0x10,0x20,0x30:
  - Required: writes (0,4), (1,16), (2,1) at T+1..T+3.
  - Required: three beats, `o_tlast` only on 0x30.
  - Required: enable=0 write, `done` with `err=0`.
- Same command with `o_tready=0` until after the 3rd strobe:
  - Required: first beat 0x10 is held.
  - Required: strobes 2 and 3 dropped, `err[1]=1`.
  - Required: `done` only after 0x10 is accepted.
- `TIMEOUT=64`, windows=2, only one strobe:
  - Required: `run` falls 64 cycles after that strobe.
  - Required: `err=3'b001`; one beat with `o_tlast=0`.
- `abort` asserted 5 cycles into MEASURE:
  - Required: `run=0` and enable=0 write within 1 cycle; `err=3'b100`; no beats.
- Command with `cmd_windows=0`:
  - Required: no settings writes, `done` the next cycle with `err=3'b100`, FSM stays in IDLE.
- `reset_n` pulsed low during MEASURE with `o_tvalid=1`:
  - Required: all outputs 0 and `cmd_ready=1` in the same cycle.
  - Required: a new command then runs normally.
